// File: rtl/dsp_accum_pkg.sv
// Shared types and default geometry for the product-sum accumulator
// and its saturating adder.
package dsp_accum_pkg;

    localparam int IN_WIDTH  = 28;
    localparam int ACC_WIDTH = 34;
    localparam int CNT_WIDTH = 6;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

endpackage

// File: rtl/sat_add_unsigned.sv
// Combinational unsigned add of a narrow operand into a wide one,
// clamped to all-ones on carry-out.
module sat_add_unsigned #(
    parameter int A_WIDTH = dsp_accum_pkg::ACC_WIDTH,
    parameter int B_WIDTH = dsp_accum_pkg::IN_WIDTH
) (
    input  logic [A_WIDTH-1:0] a,
    input  logic [B_WIDTH-1:0] b,
    output logic [A_WIDTH-1:0] sum,
    output logic               overflow
);

    logic [A_WIDTH:0] wide_sum;

    // One extra bit is enough: the sum of two values below 2^A_WIDTH fits in A_WIDTH+1 bits.
    always_comb begin
        wide_sum = {1'b0, a} + {{(A_WIDTH + 1 - B_WIDTH){1'b0}}, b};
        overflow = wide_sum[A_WIDTH];
        sum      = overflow ? {A_WIDTH{1'b1}} : wide_sum[A_WIDTH-1:0];
    end

endmodule

// File: rtl/product_sum_accumulator.sv
// Block accumulator: sums len consecutive samples into a saturating total and
// presents each completed total on a valid/ready output register.
module product_sum_accumulator #(
    parameter int IN_WIDTH  = dsp_accum_pkg::IN_WIDTH,
    parameter int ACC_WIDTH = dsp_accum_pkg::ACC_WIDTH,
    parameter int CNT_WIDTH = dsp_accum_pkg::CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CNT_WIDTH-1:0] len,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_sat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    import dsp_accum_pkg::*;

    state_t               state_reg, state_next;
    logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
    logic [CNT_WIDTH-1:0] len_reg, len_next;
    logic [CNT_WIDTH-1:0] len_eff, cnt_inc;
    logic [ACC_WIDTH-1:0] acc_reg, acc_next;
    logic [ACC_WIDTH-1:0] out_data_reg, out_data_next;
    logic [ACC_WIDTH-1:0] sum;
    logic                 sat_reg, sat_next;
    logic                 out_sat_reg, out_sat_next;
    logic                 out_valid_reg, out_valid_next;
    logic                 overflow;
    logic                 final_sample;
    logic                 accept;
    logic                 complete;

    sat_add_unsigned #(
        .A_WIDTH(ACC_WIDTH),
        .B_WIDTH(IN_WIDTH)
    ) u_sat_add (
        .a        (acc_reg),
        .b        (in_data),
        .sum      (sum),
        .overflow (overflow)
    );

    // In IDLE the block length comes straight from len; inside a block it is the latched copy.
    always_comb begin
        len_eff      = (len == '0) ? CNT_WIDTH'(1) : len;
        cnt_inc      = cnt_reg + CNT_WIDTH'(1);
        final_sample = (state_reg == IDLE) ? (len_eff == CNT_WIDTH'(1))
                                           : (cnt_inc == len_reg);
    end

    // Only a block-closing sample can be stalled, and only while the result slot is stuck.
    assign in_ready = !(final_sample && out_valid_reg && !out_ready);
    assign accept   = in_valid && in_ready;
    assign complete = accept && final_sample;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        len_next   = len_reg;
        acc_next   = acc_reg;
        sat_next   = sat_reg;
        if (accept) begin
            if (state_reg == IDLE) begin
                len_next   = len_eff;
                acc_next   = ACC_WIDTH'(in_data);
                sat_next   = 1'b0;
                cnt_next   = CNT_WIDTH'(1);
                state_next = final_sample ? IDLE : ACCUM;
            end else begin
                acc_next = sum;
                sat_next = sat_reg | overflow;
                cnt_next = cnt_inc;
                if (final_sample) begin
                    state_next = IDLE;
                end
            end
        end
    end

    // A completion overrides a drain in the same cycle, so the slot never bubbles.
    always_comb begin
        out_data_next  = out_data_reg;
        out_sat_next   = out_sat_reg;
        out_valid_next = out_valid_reg;
        if (complete) begin
            out_data_next  = acc_next;
            out_sat_next   = sat_next;
            out_valid_next = 1'b1;
        end else if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            len_reg       <= '0;
            acc_reg       <= '0;
            sat_reg       <= 1'b0;
            out_data_reg  <= '0;
            out_sat_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            len_reg       <= len_next;
            acc_reg       <= acc_next;
            sat_reg       <= sat_next;
            out_data_reg  <= out_data_next;
            out_sat_reg   <= out_sat_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign out_data  = out_data_reg;
    assign out_sat   = out_sat_reg;
    assign out_valid = out_valid_reg;
    assign busy      = (state_reg == ACCUM);

endmodule

// File: doc/product_sum_accumulator.md
# product_sum_accumulator

Block-level accumulator that sits directly downstream of the four-multiplier sum stage. It consumes the registered sum-of-products word one sample at a time and adds a programmable number of consecutive samples into a wide saturating accumulator. Each completed block total is presented on a valid/ready output register. Together with the upstream stage it forms the integrate half of the DSP block test chain.

## Interface
- IN_WIDTH, 28, width of unsigned input sample; matches upstream sum output.
- ACC_WIDTH, 34, width of accumulator and result; must be ≥ IN_WIDTH.
- CNT_WIDTH, 6, width of block-length field and sample counter.

- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset; 0 = reset, sampled on rising edge of clk.
- len  input  CNT_WIDTH  samples per block; sampled on the first accepted sample of each block; 0 is treated as 1.
- in_data  input  IN_WIDTH  unsigned sample.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a sample this cycle.
- out_data  output  ACC_WIDTH  completed block total, unsigned.
- out_sat  output  1  this block's total saturated.
- out_valid  output  1  out_data and out_sat are valid.
- out_ready  input  1  consumer takes the result this cycle.
- busy  output  1  a block is partially accumulated (state ACCUM).

## Operation
- Sample acceptance: a sample is accepted when in_valid && in_ready.
- States:
  - IDLE (no block open). Accept → latch len_q = max(len,1), acc = zero-extended in_data, cnt = 1.
    - If len_q == 1, the block completes immediately.
    - Otherwise go to ACCUM.
  - ACCUM. Accept → acc = sat(acc + in_data), cnt = cnt + 1.
    - When cnt + 1 == len_q, the block completes and the state returns to IDLE.
- Saturation: if the true sum exceeds 2^ACC_WIDTH − 1, acc clamps to all-ones and a sticky sat_q is set for the rest of the block. sat_q clears when the block opens. Saturation cannot occur on the first sample.
- Completion:
  - out_data ← final acc.
  - out_sat ← final sat_q.
  - out_valid ← 1.
- Output register:
  - out_valid clears when out_valid && out_ready, unless a new completion happens in the same cycle.
  - out_data and out_sat stay stable while out_valid && !out_ready.
- Backpressure: in_ready = 0 only when the next accepted sample would complete a block and the output register is occupied and not draining (out_valid && !out_ready). Non-final samples are never stalled. in_ready does not depend on in_valid.
- Changing len mid-block has no effect until the next block opens.

## Timing
- Reset values:
  - out_data = 0, out_sat = 0, out_valid = 0, busy = 0.
  - state = IDLE, cnt = 0, acc = 0, sat_q = 0.
  - in_ready = 1.
- Latency: final sample accepted at edge t → out_valid = 1 with result after edge t (visible in cycle t+1).
- Throughput: one sample per cycle; back-to-back blocks need no idle cycle.
- Simultaneous drain and completion: output is replaced in the same edge and out_valid stays 1 with no bubble.
- Reset mid-block: the partial sum is discarded and a pending output is dropped.
- No sample is accepted in the reset cycle.
- busy rises the cycle after the first accepted sample of a block with len_q > 1. It falls the cycle after completion.

## Structure
- Shared package dsp_accum_pkg:
  - state enum {IDLE, ACCUM}.
  - Default width constants IN_WIDTH, ACC_WIDTH, CNT_WIDTH.
  - Constant ACC_MAX = all-ones.
- One sub-module: sat_add_unsigned (ACC_WIDTH + IN_WIDTH → ACC_WIDTH clamp, plus overflow flag), combinational.
- The top level holds the FSM, counter, accumulator and output register.

## Test plan
- Basic block: len = 4, in_data = 100, 200, 300, 400 back-to-back, out_ready = 1 → one out_valid pulse, out_data = 1000, out_sat = 0, one cycle after the 4th accept.
- len = 0 and len = 1: in_data = 7 → out_data = 7 each sample; consecutive samples give consecutive one-cycle results.
- Saturation: ACC_WIDTH = 28 override, len = 2, in_data = 2^28 − 1 twice → out_data = 2^28 − 1, out_sat = 1. The next block, 5 + 6, gives 11 with out_sat = 0.
- Backpressure: len = 2, out_ready = 0 after the first result.
  - Non-final samples are accepted while the output is occupied.
  - in_ready = 0 on the final sample until out_ready = 1.
  - The drain cycle accepts the final sample; the next result appears after no bubble cycle.
  - No result is lost.
- Reset mid-block: len = 8, 3 samples accepted, reset = 0 for 1 cycle → all outputs return to reset values. A fresh len = 2 block (1, 2) gives 3.
- len change mid-block: len 4 → 2 after the 1st sample → the block still closes after 4 samples.
